pipe_adder: RTL and testbench

- Parametrised, pipelined signed/unsigned add/subtract unit. Successor to the single-cycle combinational 32-bit adder.
- Splits the NUM_SIZE carry chain into NUM_STAGES registered chunks, so it meets timing at the RV32I core clock.
- Adds a valid/ready handshake with backpressure, a subtract mode, and carry/zero flags.
- Serves as the ALU add path and the address-generation adder.

---
 rtl/pipe_adder_pkg.sv | 17 +
 rtl/adder_stage.sv | 26 ++
 rtl/pipe_adder.sv | 181 ++++++++++++++++++
 tb/tb_pipe_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB   : encodings of the 'sub' mode input
//   DEFAULT_NUM_SIZE  : default operand width
//   size_ok()         : elaboration-time check of the width/depth pairing
package pipe_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_NUM_SIZE = 32;

    // Width must split evenly into stage chunks, depth 1..width.
    function automatic bit size_ok(input int size, input int stages);
        return (stages >= 1) && (stages <= size) && ((size % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// adder_stage: one chunk of the skewed carry chain, plain ripple add.
//   a, b  : operand chunks (b already conditioned for subtract)
//   cin   : carry from the previous chunk (or the subtract carry-in)
//   s     : chunk sum
//   cout  : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (only the last stage uses it, for overflow)
module adder_stage #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    input  logic               cin,
    output logic [CHUNK_W-1:0] s,
    output logic               cout,
    output logic               cmsb
);

    logic [CHUNK_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
    assign s    = full[CHUNK_W-1:0];
    assign cout = full[CHUNK_W];
    // The MSB sum bit is a ^ b ^ carry-in-to-MSB, so the carry is recovered from it.
    assign cmsb = s[CHUNK_W-1] ^ a[CHUNK_W-1] ^ b[CHUNK_W-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract with valid/ready handshake and flags.
// The carry chain is cut into NUM_STAGES chunks; stage k resolves chunk k and
// registers it with the carry, the still-unused upper operand chunks and the
// lower result chunks already produced. The last stage is the output register.
//   clk, rstN          : clock, asynchronous active-low reset
//   inValid / inReady  : operand beat handshake (inReady = pipe may advance)
//   dIn0, dIn1, sub    : operands A, B; sub=1 computes A-B
//   outValid / outReady: result handshake
//   sum                : result, modulo 2^NUM_SIZE
//   carryOut           : carry out of the MSB (for subtract 1 = no borrow)
//   overflow           : signed overflow
//   zero               : unclamped sum == 0
// Optional macro PIPE_ADDER_SATURATE_EN adds input 'sat': on signed overflow
// the presented sum is clamped to the most positive/negative value; flags
// still describe the unclamped result.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int NUM_SIZE   = DEFAULT_NUM_SIZE,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                inValid,
    output logic                inReady,
    input  logic [NUM_SIZE-1:0] dIn0,
    input  logic [NUM_SIZE-1:0] dIn1,
    input  logic                sub,
`ifdef PIPE_ADDER_SATURATE_EN
    input  logic                sat,
`endif
    output logic                outValid,
    input  logic                outReady,
    output logic [NUM_SIZE-1:0] sum,
    output logic                carryOut,
    output logic                overflow,
    output logic                zero
);

    localparam int CHUNK_W = NUM_SIZE / NUM_STAGES;

    if (!size_ok(NUM_SIZE, NUM_STAGES)) begin : g_bad_cfg
        $error("pipe_adder: NUM_SIZE must be a multiple of NUM_STAGES (1..NUM_SIZE)");
    end

    // Whole pipe moves together; only a full, unconsumed output stalls it.
    logic adv;
    assign adv     = !outValid || outReady;
    assign inReady = adv;

    logic [NUM_SIZE-1:0] sum_q;
    logic                cmsb_all [NUM_STAGES];

`ifdef PIPE_ADDER_SATURATE_EN
    logic sat_q;
    logic a_neg_q;

    function automatic logic [NUM_SIZE-1:0] saturate(
        input logic [NUM_SIZE-1:0] s,
        input logic                en,
        input logic                ovf,
        input logic                a_neg
    );
        if (en && ovf)
            return a_neg ? {1'b1, {(NUM_SIZE-1){1'b0}}} : {1'b0, {(NUM_SIZE-1){1'b1}}};
        return s;
    endfunction

    assign sum = saturate(sum_q, sat_q, overflow, a_neg_q);
`else
    assign sum = sum_q;
`endif

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        // Operand bits not yet consumed; chunk k sits at the bottom.
        localparam int REM = NUM_SIZE - k * CHUNK_W;

        logic [REM-1:0]             a_in;
        logic [REM-1:0]             b_in;
        logic                       c_in;
        logic                       v_in;
        logic [CHUNK_W-1:0]         s_chunk;
        logic                       c_out;
        logic [(k+1)*CHUNK_W-1:0]   res_next;
`ifdef PIPE_ADDER_SATURATE_EN
        logic                       sat_in;
`endif

        if (k == 0) begin : g_src
            // ---- stage 0: operand conditioning, B' = ~B and carry-in = 1 for subtract
            assign a_in     = dIn0;
            assign b_in     = (sub == OP_SUB) ? ~dIn1 : dIn1;
            assign c_in     = (sub == OP_SUB);
            assign v_in     = inValid;
            assign res_next = s_chunk;
`ifdef PIPE_ADDER_SATURATE_EN
            assign sat_in   = sat;
`endif
        end else begin : g_src
            // ---- stage k: consume registered state of stage k-1
            assign a_in     = g_stage[k-1].g_reg.a_q;
            assign b_in     = g_stage[k-1].g_reg.b_q;
            assign c_in     = g_stage[k-1].g_reg.c_q;
            assign v_in     = g_stage[k-1].g_reg.v_q;
            assign res_next = {s_chunk, g_stage[k-1].g_reg.res_q};
`ifdef PIPE_ADDER_SATURATE_EN
            assign sat_in   = g_stage[k-1].g_reg.sat_q;
`endif
        end

        adder_stage #(
            .CHUNK_W (CHUNK_W)
        ) u_adder_stage (
            .a    (a_in[CHUNK_W-1:0]),
            .b    (b_in[CHUNK_W-1:0]),
            .cin  (c_in),
            .s    (s_chunk),
            .cout (c_out),
            .cmsb (cmsb_all[k])
        );

        if (k < NUM_STAGES - 1) begin : g_reg
            logic [REM-CHUNK_W-1:0]   a_q;
            logic [REM-CHUNK_W-1:0]   b_q;
            logic [(k+1)*CHUNK_W-1:0] res_q;
            logic                     c_q;
            logic                     v_q;
`ifdef PIPE_ADDER_SATURATE_EN
            logic                     sat_q;
`endif

            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN)
                    v_q <= 1'b0;
                else if (adv)
                    v_q <= v_in;
            end

            // Data follows its valid bit; bubbles leave it untouched.
            always_ff @(posedge clk) begin
                if (adv && v_in) begin
                    a_q   <= a_in[REM-1:CHUNK_W];
                    b_q   <= b_in[REM-1:CHUNK_W];
                    res_q <= res_next;
                    c_q   <= c_out;
`ifdef PIPE_ADDER_SATURATE_EN
                    sat_q <= sat_in;
`endif
                end
            end
        end else begin : g_out
            // ---- final stage: output register with flags
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    outValid <= 1'b0;
                    sum_q    <= '0;
                    carryOut <= 1'b0;
                    overflow <= 1'b0;
                    zero     <= 1'b0;
`ifdef PIPE_ADDER_SATURATE_EN
                    sat_q    <= 1'b0;
                    a_neg_q  <= 1'b0;
`endif
                end else if (adv) begin
                    outValid <= v_in;
                    if (v_in) begin
                        sum_q    <= res_next;
                        carryOut <= c_out;
                        overflow <= c_out ^ cmsb_all[k];
                        zero     <= (res_next == '0);
`ifdef PIPE_ADDER_SATURATE_EN
                        sat_q    <= sat_in;
                        a_neg_q  <= a_in[CHUNK_W-1];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

    localparam int NUM_SIZE   = 32;
    localparam int NUM_STAGES = 4;
`ifdef PIPE_ADDER_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] dIn0 = '0;
    logic [31:0] dIn1 = '0;
    logic        sub = 1'b0;
    logic        sat_i = 1'b0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] sum;
    logic        carryOut;
    logic        overflow;
    logic        zero;

    always #5 clk = ~clk;

    int pe = 0;
    always @(posedge clk) pe <= pe + 1;

    pipe_adder #(
        .NUM_SIZE   (NUM_SIZE),
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .dIn0     (dIn0),
        .dIn1     (dIn1),
        .sub      (sub),
`ifdef PIPE_ADDER_SATURATE_EN
        .sat      (sat_i),
`endif
        .outValid (outValid),
        .outReady (outReady),
        .sum      (sum),
        .carryOut (carryOut),
        .overflow (overflow),
        .zero     (zero)
    );

    typedef struct {
        logic [31:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    bit          front_seen = 0;
    int          front_first = 0;
    bit          prev_stall = 0;
    logic [34:0] prev_out = '0;
    bit          dummy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer arithmetic on the mathematical values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                   input logic st, input int acc, input bit lat);
        exp_t   e;
        longint ra, rb, r, ua, ub;
        ra = longint'($signed(a));
        rb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = s ? (ra - rb) : (ra + rb);
        e.sum = s ? (a - b) : (a + b);
        e.co  = s ? (ua >= ub) : ((ua + ub) > 64'sh0_FFFF_FFFF);
        e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.z   = (e.sum == 32'h0);
        if (SAT_EN && st && e.ov)
            e.sum = (r < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.acc = acc;
        e.lat = lat;
        return e;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One cycle: drive at negedge, sample 1 time unit later.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic st, input logic ordy, input bit lat,
                        output bit accepted);
        exp_t e;
        @(negedge clk);
        inValid  = v;
        dIn0     = a;
        dIn1     = b;
        sub      = s;
        sat_i    = st;
        outReady = ordy;
        #1;
        if (prev_stall)
            check_eq("hold", {outValid, sum, carryOut, overflow, zero}, {1'b1, prev_out});
        if (outValid) begin
            check_eq("out_has_beat", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                if (!front_seen) begin
                    front_seen  = 1;
                    front_first = pe;
                end
                if (outReady) begin
                    e = q.pop_front();
                    check_eq("sum", sum, e.sum);
                    check_eq("carryOut", carryOut, e.co);
                    check_eq("overflow", overflow, e.ov);
                    check_eq("zero", zero, e.z);
                    if (e.lat)
                        check_eq("latency", front_first - e.acc, NUM_STAGES);
                    front_seen = 0;
                end
            end
        end
        prev_stall = outValid && !outReady;
        prev_out   = {sum, carryOut, overflow, zero};
        check_eq("in_ready", inReady, !(outValid && !outReady));
        accepted = v && inReady;
        if (accepted)
            q.push_back(model(a, b, s, st, pe, lat));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++)
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
        check_eq("drain", q.size(), 0);
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
    endtask

    task automatic one(input logic [31:0] a, input logic [31:0] b, input logic s, input logic st);
        step(1'b1, a, b, s, st, 1'b1, 1'b1, dummy);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_outValid", outValid, 1'b0);
        check_eq("rst_sum", sum, 32'h0);
        check_eq("rst_flags", {carryOut, overflow, zero}, 3'b000);
        rstN = 1'b1;
        #1;
        check_eq("rst_inReady", inReady, 1'b1);

        // directed corner cases, each with a latency check
        one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        one(32'd5, 32'd5, 1'b1, 1'b0);
        one(32'd3, 32'd5, 1'b1, 1'b0);
        one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);

        // back-to-back random beats at full rate
        for (int i = 0; i < 20; i++)
            step(1'b1, rnd32(), rnd32(), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1, dummy);
        drain();

        // 8 beats with outReady low on cycles 3..5; retry until each is taken
        begin
            int          n;
            int          c;
            bit          acc;
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            n = 0;
            c = 0;
            a = rnd32();
            b = rnd32();
            s = 1'($urandom_range(0, 1));
            while (n < 8 && c < 40) begin
                step(1'b1, a, b, s, 1'b0, !(c >= 3 && c <= 5), 1'b0, acc);
                if (acc) begin
                    n++;
                    a = rnd32();
                    b = rnd32();
                    s = 1'($urandom_range(0, 1));
                end
                c++;
            end
            check_eq("stall_beats_taken", n, 8);
            drain();
        end

        // random valid/ready mix
        for (int i = 0; i < 150; i++)
            step(1'($urandom_range(0, 3) != 0), rnd32(), rnd32(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, dummy);
        drain();

        // reset with three beats in flight
        for (int i = 0; i < 3; i++)
            step(1'b1, rnd32(), rnd32(), 1'b0, 1'b0, 1'b1, 1'b0, dummy);
        @(negedge clk);
        inValid = 1'b0;
        rstN    = 1'b0;
        #1;
        check_eq("midrst_outValid", outValid, 1'b0);
        check_eq("midrst_sum", sum, 32'h0);
        @(negedge clk);
        #1;
        check_eq("midrst_outValid_hold", outValid, 1'b0);
        rstN = 1'b1;
        q.delete();
        front_seen = 0;
        prev_stall = 0;
        #1;
        check_eq("midrst_inReady", inReady, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, dummy);
            check_eq("post_rst_outValid", outValid, 1'b0);
        end
        one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

`ifdef PIPE_ADDER_SATURATE_EN
        one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        one(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
